// File: rtl/train_sequencer.sv
// Training/inference sequencer: fetches samples, hands them to a neuron, turns results
// into errors and per-epoch absolute-error loss, and walks the epoch/sample loop.
module train_sequencer #(
  parameter int N       = 2,
  parameter int SAMPLES = 4,
  parameter int EPOCHS  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  input  logic              sample_valid,
  input  logic [N*8-1:0]    sample_argument,
  input  logic [15:0]       sample_target,
  output logic              sample_ready,
  output logic              train,
  output logic              argument_valid,
  output logic [N*8-1:0]    argument_data,
  input  logic              argument_ready,
  input  logic              result_valid,
  input  logic [15:0]       result_data,
  output logic              result_ready,
  output logic              error_valid,
  output logic [15:0]       error_data,
  input  logic              error_ready,
  input  logic              propagate_valid,
  input  logic [N*16-1:0]   propagate_data,
  output logic              propagate_ready,
  output logic              loss_valid,
  output logic [23:0]       loss_data,
  input  logic              loss_ready
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ARG,
    RES,
    ERR,
    PRP,
    NEXT,
    LOSS
  } state_t;

  localparam int SW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam int EW = $clog2(EPOCHS + 1);
  localparam logic [SW-1:0] LAST_SAMPLE = SW'(SAMPLES - 1);
  localparam logic [EW-1:0] EPOCH_COUNT = EW'(EPOCHS);

  state_t        state;
  logic [SW-1:0] sample_count;
  logic [EW-1:0] epoch_count;
  logic [EW-1:0] epoch_inc;
  logic [15:0]   target_q;
  logic [23:0]   loss_acc;
  logic [16:0]   diff;
  logic [15:0]   error_next;
  logic [16:0]   error_mag;
  logic [24:0]   loss_sum;
  logic [23:0]   loss_next;
  logic          propagate_unused;

  // The neuron's gradient is not needed here; it is only consumed to complete the handshake.
  assign propagate_unused = ^propagate_data;

  assign loss_data = loss_acc;
  assign epoch_inc = epoch_count + EW'(1);
  assign diff      = {target_q[15], target_q} - {result_data[15], result_data};

  // Saturate the 17-bit difference into 16 bits, then take its magnitude (|-32768| = 32768).
  always_comb begin
    error_next = diff[15:0];
    if (diff[16] != diff[15]) begin
      error_next = diff[16] ? 16'h8000 : 16'h7FFF;
    end
    error_mag = error_next[15] ? (17'd0 - {1'b1, error_next}) : {1'b0, error_next};
    loss_sum  = {1'b0, loss_acc} + {8'd0, error_mag};
    loss_next = loss_sum[24] ? 24'hFFFFFF : loss_sum[23:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      train           <= 1'b0;
      sample_ready    <= 1'b0;
      argument_valid  <= 1'b0;
      result_ready    <= 1'b0;
      error_valid     <= 1'b0;
      propagate_ready <= 1'b0;
      loss_valid      <= 1'b0;
      argument_data   <= '0;
      target_q        <= '0;
      error_data      <= '0;
      loss_acc        <= '0;
      sample_count    <= '0;
      epoch_count     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            train        <= mode;
            sample_count <= '0;
            epoch_count  <= '0;
            loss_acc     <= '0;
            busy         <= 1'b1;
            sample_ready <= 1'b1;
            state        <= FETCH;
          end
        end
        FETCH: begin
          if (sample_valid && sample_ready) begin
            argument_data  <= sample_argument;
            target_q       <= sample_target;
            sample_ready   <= 1'b0;
            argument_valid <= 1'b1;
            state          <= ARG;
          end
        end
        ARG: begin
          if (argument_valid && argument_ready) begin
            argument_valid <= 1'b0;
            result_ready   <= 1'b1;
            state          <= RES;
          end
        end
        RES: begin
          if (result_valid && result_ready) begin
            error_data   <= error_next;
            loss_acc     <= loss_next;
            result_ready <= 1'b0;
            if (train) begin
              error_valid <= 1'b1;
              state       <= ERR;
            end else begin
              state <= NEXT;
            end
          end
        end
        ERR: begin
          if (error_valid && error_ready) begin
            error_valid     <= 1'b0;
            propagate_ready <= 1'b1;
            state           <= PRP;
          end
        end
        PRP: begin
          if (propagate_valid && propagate_ready) begin
            propagate_ready <= 1'b0;
            state           <= NEXT;
          end
        end
        NEXT: begin
          if (sample_count < LAST_SAMPLE) begin
            sample_count <= sample_count + SW'(1);
            sample_ready <= 1'b1;
            state        <= FETCH;
          end else begin
            sample_count <= '0;
            loss_valid   <= 1'b1;
            state        <= LOSS;
          end
        end
        LOSS: begin
          if (loss_valid && loss_ready) begin
            loss_valid  <= 1'b0;
            loss_acc    <= '0;
            epoch_count <= epoch_inc;
            if (epoch_inc == EPOCH_COUNT) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              sample_ready <= 1'b1;
              state        <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_train_sequencer.sv
// Bench for train_sequencer: three instances (2x1, 2x3 and a long 520-sample epoch),
// directed table runs, reset abort, start noise and randomized runs against a loss model.
module tb_train_sequencer;

  localparam int ND  = 3;
  localparam int BIG = 520;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        start [ND];
  logic        mode [ND];
  logic        sample_valid [ND];
  logic [15:0] sample_argument [ND];
  logic [15:0] sample_target [ND];
  logic        argument_ready [ND];
  logic        result_valid [ND];
  logic [15:0] result_data [ND];
  logic        error_ready [ND];
  logic        propagate_valid [ND];
  logic [31:0] propagate_data [ND];
  logic        loss_ready [ND];
  logic        busy [ND];
  logic        done [ND];
  logic        sample_ready [ND];
  logic        train [ND];
  logic        argument_valid [ND];
  logic [15:0] argument_data [ND];
  logic        result_ready [ND];
  logic        error_valid [ND];
  logic [15:0] error_data [ND];
  logic        propagate_ready [ND];
  logic        loss_valid [ND];
  logic [23:0] loss_data [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    train_sequencer #(
      .N(2),
      .SAMPLES(g == 2 ? BIG : 2),
      .EPOCHS(g == 1 ? 3 : 1)
    ) dut (
      .clock(clock),
      .reset(reset),
      .start(start[g]),
      .mode(mode[g]),
      .busy(busy[g]),
      .done(done[g]),
      .sample_valid(sample_valid[g]),
      .sample_argument(sample_argument[g]),
      .sample_target(sample_target[g]),
      .sample_ready(sample_ready[g]),
      .train(train[g]),
      .argument_valid(argument_valid[g]),
      .argument_data(argument_data[g]),
      .argument_ready(argument_ready[g]),
      .result_valid(result_valid[g]),
      .result_data(result_data[g]),
      .result_ready(result_ready[g]),
      .error_valid(error_valid[g]),
      .error_data(error_data[g]),
      .error_ready(error_ready[g]),
      .propagate_valid(propagate_valid[g]),
      .propagate_data(propagate_data[g]),
      .propagate_ready(propagate_ready[g]),
      .loss_valid(loss_valid[g]),
      .loss_data(loss_data[g]),
      .loss_ready(loss_ready[g])
    );
  end

  int checks = 0;
  int errors = 0;
  bit noiseOn = 1'b0;

  int lossHs [ND];
  int doneCnt [ND];
  int errCycles [ND];
  int prpCycles [ND];
  int sampleHs [ND];
  int protoViol [ND];

  // Event counters sampled on the active edge, plus one-hot/busy protocol watch.
  always @(posedge clock) begin
    for (int d = 0; d < ND; d++) begin
      if (loss_valid[d] && loss_ready[d]) lossHs[d]++;
      if (sample_valid[d] && sample_ready[d]) sampleHs[d]++;
      if (done[d]) doneCnt[d]++;
      if (error_valid[d]) errCycles[d]++;
      if (propagate_ready[d]) prpCycles[d]++;
      if ($countones({argument_valid[d], result_ready[d], error_valid[d], propagate_ready[d]}) > 1)
        protoViol[d]++;
      if (!busy[d] && (sample_ready[d] || argument_valid[d] || result_ready[d] ||
                       error_valid[d] || propagate_ready[d] || loss_valid[d]))
        protoViol[d]++;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (noiseOn) begin
      start[1] = 1'($urandom);
      mode[1]  = 1'($urandom);
    end
  endtask

  function automatic logic sigOf(input int d, input int sel);
    case (sel)
      0:       return sample_ready[d];
      1:       return loss_valid[d];
      default: return 1'b0;
    endcase
  endfunction

  task automatic waitUntil(input int d, input int sel, input string name);
    int k = 0;
    while (!sigOf(d, sel) && k < 100) begin
      step();
      k++;
    end
    checkOutput({name, " reached"}, 32'(sigOf(d, sel)), 32'd1);
  endtask

  // Reference model: signed difference clamped to 16 bits.
  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int pick16();
    logic [15:0] x;
    x = 16'($urandom);
    case ($urandom_range(0, 3))
      0:       return 32767;
      1:       return -32768;
      default: return int'($signed(x));
    endcase
  endfunction

  task automatic startRun(input int d, input bit m);
    checkOutput("idle busy", 32'(busy[d]), 32'd0);
    start[d] = 1'b1;
    mode[d]  = m;
    step();
    start[d] = 1'b0;
    mode[d]  = ~m;
    checkOutput("run busy", 32'(busy[d]), 32'd1);
    checkOutput("train latched", 32'(train[d]), 32'(m));
    checkOutput("fetch ready", 32'(sample_ready[d]), 32'd1);
  endtask

  task automatic applyStimulus(input int d, input logic [15:0] arg, input int tgt);
    waitUntil(d, 0, "sample_ready");
    sample_valid[d]    = 1'b1;
    sample_argument[d] = arg;
    sample_target[d]   = 16'(tgt);
    step();
    sample_valid[d]    = 1'b0;
    sample_argument[d] = 16'($urandom);
  endtask

  task automatic runSample(input int d, input logic [15:0] arg, input int tgt, input int res,
                           input int expErr, input bit trn, input int stall);
    logic [15:0] e16;
    e16 = 16'(expErr);
    applyStimulus(d, arg, tgt);
    checkOutput("argument_valid", 32'(argument_valid[d]), 32'd1);
    checkOutput("argument_data", 32'(argument_data[d]), 32'(arg));
    for (int s = 0; s < stall; s++) begin
      step();
      checkOutput("argument_valid held", 32'(argument_valid[d]), 32'd1);
      checkOutput("argument_data held", 32'(argument_data[d]), 32'(arg));
    end
    argument_ready[d] = 1'b1;
    step();
    argument_ready[d] = 1'b0;
    checkOutput("argument_valid drop", 32'(argument_valid[d]), 32'd0);
    checkOutput("result_ready", 32'(result_ready[d]), 32'd1);
    result_valid[d] = 1'b1;
    result_data[d]  = 16'(res);
    step();
    result_valid[d] = 1'b0;
    checkOutput("result_ready drop", 32'(result_ready[d]), 32'd0);
    if (trn) begin
      checkOutput("error_valid", 32'(error_valid[d]), 32'd1);
      checkOutput("error_data", 32'(error_data[d]), 32'(e16));
      for (int s = 0; s < stall; s++) begin
        step();
        checkOutput("error_valid held", 32'(error_valid[d]), 32'd1);
        checkOutput("error_data held", 32'(error_data[d]), 32'(e16));
      end
      error_ready[d] = 1'b1;
      step();
      error_ready[d] = 1'b0;
      checkOutput("error_valid drop", 32'(error_valid[d]), 32'd0);
      checkOutput("propagate_ready", 32'(propagate_ready[d]), 32'd1);
      propagate_valid[d] = 1'b1;
      propagate_data[d]  = $urandom;
      step();
      propagate_valid[d] = 1'b0;
      checkOutput("propagate_ready drop", 32'(propagate_ready[d]), 32'd0);
    end else begin
      checkOutput("infer error_valid", 32'(error_valid[d]), 32'd0);
    end
    checkOutput("busy in run", 32'(busy[d]), 32'd1);
    checkOutput("train stable", 32'(train[d]), 32'(trn));
  endtask

  task automatic runLoss(input int d, input int expLoss, input int stall, input bit expDone);
    waitUntil(d, 1, "loss_valid");
    checkOutput("loss_data", 32'(loss_data[d]), 32'(expLoss));
    for (int s = 0; s < stall; s++) begin
      step();
      checkOutput("loss_valid held", 32'(loss_valid[d]), 32'd1);
      checkOutput("loss_data held", 32'(loss_data[d]), 32'(expLoss));
    end
    loss_ready[d] = 1'b1;
    step();
    loss_ready[d] = 1'b0;
    checkOutput("loss_valid drop", 32'(loss_valid[d]), 32'd0);
    checkOutput("done pulse", 32'(done[d]), 32'(expDone));
    checkOutput("busy after loss", 32'(busy[d]), 32'(!expDone));
    if (expDone) begin
      step();
      checkOutput("done one cycle", 32'(done[d]), 32'd0);
    end
  endtask

  task automatic runRandomRun(input int d, input bit m, input int epochs, input int samples,
                              input int stall, input bit noisy);
    int sum;
    int e;
    int t;
    int r;
    startRun(d, m);
    noiseOn = noisy;
    for (int ep = 0; ep < epochs; ep++) begin
      sum = 0;
      for (int s = 0; s < samples; s++) begin
        t = pick16();
        r = pick16();
        e = sat16(t - r);
        runSample(d, 16'($urandom), t, r, e, m, stall);
        sum += (e < 0) ? -e : e;
      end
      if (ep == epochs - 1) begin
        noiseOn  = 1'b0;
        start[d] = 1'b0;
      end
      runLoss(d, (sum > 16777215) ? 16777215 : sum, stall, ep == epochs - 1);
    end
  endtask

  typedef struct {
    bit m;
    int stall;
    int t0, r0, e0;
    int t1, r1, e1;
    int loss;
  } run_t;

  initial begin
    run_t runs [5];
    int errBefore, prpBefore, smpBefore, doneBefore, lossBefore, sum;

    runs[0] = '{1'b1, 0, 100, 40, 60, -50, 10, -60, 120};
    runs[1] = '{1'b0, 0, 0, 32767, -32767, 0, 32767, -32767, 65534};
    runs[2] = '{1'b1, 0, -32768, 32767, -32768, 32767, -32768, 32767, 65535};
    runs[3] = '{1'b1, 5, 1000, -1000, 2000, -5, -5, 0, 2000};
    runs[4] = '{1'b1, 2, -20000, 20000, -32768, 300, -300, 600, 33368};

    for (int d = 0; d < ND; d++) begin
      lossHs[d] = 0; doneCnt[d] = 0; errCycles[d] = 0;
      prpCycles[d] = 0; sampleHs[d] = 0; protoViol[d] = 0;
      start[d] = 0; mode[d] = 0; sample_valid[d] = 0; sample_argument[d] = 0;
      sample_target[d] = 0; argument_ready[d] = 0; result_valid[d] = 0; result_data[d] = 0;
      error_ready[d] = 0; propagate_valid[d] = 0; propagate_data[d] = 0; loss_ready[d] = 0;
    end
    reset = 1'b1;
    repeat (3) step();
    for (int d = 0; d < ND; d++) begin
      checkOutput("reset busy", 32'(busy[d]), 32'd0);
      checkOutput("reset done", 32'(done[d]), 32'd0);
      checkOutput("reset train", 32'(train[d]), 32'd0);
      checkOutput("reset sample_ready", 32'(sample_ready[d]), 32'd0);
      checkOutput("reset argument_valid", 32'(argument_valid[d]), 32'd0);
      checkOutput("reset result_ready", 32'(result_ready[d]), 32'd0);
      checkOutput("reset error_valid", 32'(error_valid[d]), 32'd0);
      checkOutput("reset propagate_ready", 32'(propagate_ready[d]), 32'd0);
      checkOutput("reset loss_valid", 32'(loss_valid[d]), 32'd0);
      checkOutput("reset argument_data", 32'(argument_data[d]), 32'd0);
      checkOutput("reset error_data", 32'(error_data[d]), 32'd0);
      checkOutput("reset loss_data", 32'(loss_data[d]), 32'd0);
    end
    reset = 1'b0;
    step();

    $display("[TB] directed table runs");
    for (int i = 0; i < 5; i++) begin
      errBefore = errCycles[0];
      prpBefore = prpCycles[0];
      smpBefore = sampleHs[0];
      startRun(0, runs[i].m);
      runSample(0, 16'($urandom), runs[i].t0, runs[i].r0, runs[i].e0, runs[i].m, runs[i].stall);
      runSample(0, 16'($urandom), runs[i].t1, runs[i].r1, runs[i].e1, runs[i].m, runs[i].stall);
      runLoss(0, runs[i].loss, runs[i].stall, 1'b1);
      checkOutput("error_valid cycles", 32'(errCycles[0] - errBefore),
                  32'(runs[i].m ? 2 * (1 + runs[i].stall) : 0));
      checkOutput("propagate_ready cycles", 32'(prpCycles[0] - prpBefore), 32'(runs[i].m ? 2 : 0));
      checkOutput("samples accepted", 32'(sampleHs[0] - smpBefore), 32'd2);
    end

    $display("[TB] reset while waiting on error handshake");
    startRun(0, 1'b1);
    applyStimulus(0, 16'h1234, 500);
    argument_ready[0] = 1'b1;
    step();
    argument_ready[0] = 1'b0;
    result_valid[0] = 1'b1;
    result_data[0]  = 16'd100;
    step();
    result_valid[0] = 1'b0;
    checkOutput("pre-abort error_valid", 32'(error_valid[0]), 32'd1);
    checkOutput("pre-abort error_data", 32'(error_data[0]), 32'd400);
    doneBefore = doneCnt[0];
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("abort error_valid", 32'(error_valid[0]), 32'd0);
    checkOutput("abort busy", 32'(busy[0]), 32'd0);
    checkOutput("abort loss_data", 32'(loss_data[0]), 32'd0);
    step();
    checkOutput("abort no done", 32'(doneCnt[0] - doneBefore), 32'd0);
    startRun(0, 1'b1);
    runSample(0, 16'h00AA, 7, 3, 4, 1'b1, 0);
    runSample(0, 16'h00BB, -7, 3, -10, 1'b1, 0);
    runLoss(0, 14, 0, 1'b1);

    $display("[TB] three epochs with start and mode noise");
    lossBefore = lossHs[1];
    doneBefore = doneCnt[1];
    runRandomRun(1, 1'b1, 3, 2, 1, 1'b1);
    repeat (5) step();
    checkOutput("loss handshakes", 32'(lossHs[1] - lossBefore), 32'd3);
    checkOutput("done pulses", 32'(doneCnt[1] - doneBefore), 32'd1);
    checkOutput("no restart", 32'(busy[1]), 32'd0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      runRandomRun(0, 1'($urandom), 1, 2, $urandom_range(0, 3), 1'b0);
    end
    runRandomRun(1, 1'b0, 3, 2, 0, 1'b0);

    $display("[TB] loss saturation over a long epoch");
    startRun(2, 1'b0);
    sum = 0;
    for (int s = 0; s < BIG; s++) begin
      runSample(2, 16'($urandom), -32768, 32767, -32768, 1'b0, 0);
      sum += 32768;
    end
    runLoss(2, (sum > 16777215) ? 16777215 : sum, 1, 1'b1);

    for (int d = 0; d < ND; d++) begin
      checkOutput("protocol violations", 32'(protoViol[d]), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/train_sequencer.md
TRAIN_SEQUENCER -- requirements
Module: train_sequencer

Interface
REQ-001 SHALL have parameter N, default 2: arguments per sample.
REQ-002 SHALL have parameter SAMPLES, default 4: samples per epoch, at least 1.
REQ-003 SHALL have parameter EPOCHS, default 16: epochs per run, at least 1.
REQ-004 SHALL have ports: clock input 1 (rising-edge clock); reset input 1 (synchronous, active-high).
REQ-005 SHALL have ports: start input 1 (begin run, sampled in IDLE only); mode input 1 (1 = train, 0 = infer, latched at start); busy output 1; done output 1 (one-cycle pulse at end of run).
REQ-006 SHALL have ports: sample_valid input 1; sample_argument input N*8 (N unsigned bytes); sample_target input 16 (signed); sample_ready output 1.
REQ-007 SHALL have neuron-side ports: train output 1; argument_valid output 1; argument_data output N*8; argument_ready input 1; result_valid input 1; result_data input 16; result_ready output 1.
REQ-008 SHALL have neuron-side ports: error_valid output 1; error_data output 16; error_ready input 1; propagate_valid input 1; propagate_data input N*16 (discarded); propagate_ready output 1.
REQ-009 SHALL have ports: loss_valid output 1; loss_data output 24 (unsigned); loss_ready input 1.

Function
REQ-010 SHALL implement states IDLE, FETCH, ARG, RES, ERR, PRP, NEXT, LOSS, with a 1-cycle done pulse on return to IDLE.
REQ-011 IDLE: busy=0; if start=1, SHALL latch mode into train, clear sample, epoch and loss counters, and go to FETCH.
REQ-012 FETCH: sample_ready=1; on sample_valid&sample_ready SHALL register argument and target, then go to ARG.
REQ-013 ARG: argument_valid=1 with registered argument_data; on argument_ready SHALL go to RES; argument_valid SHALL drop the cycle after the handshake.
REQ-014 RES: result_ready=1; on result_valid SHALL register error = sat16(target - result) (17-bit signed difference, clamped to [-32768, 32767]), add |error| to the loss accumulator, then go to ERR if train=1, else to NEXT.
REQ-015 Loss accumulation SHALL saturate at 24'hFFFFFF; |-32768| SHALL count as 32768.
REQ-016 ERR: error_valid=1 with error_data=error, held stable until error_ready; on handshake SHALL go to PRP.
REQ-017 PRP: propagate_ready=1; on propagate_valid SHALL go to NEXT, and propagate_data SHALL be ignored.
REQ-018 NEXT: if sample counter < SAMPLES-1, SHALL increment it and go to FETCH; otherwise SHALL wrap it to 0 and go to LOSS.
REQ-019 LOSS: loss_valid=1 with loss_data = epoch accumulator, held until loss_ready. On handshake SHALL clear the accumulator and increment epoch; if epoch reaches EPOCHS, SHALL pulse done and go to IDLE, otherwise go to FETCH.
REQ-020 In any state other than IDLE, busy SHALL be 1.
REQ-021 All valid/ready outputs SHALL be 0 outside their own states, and at most one neuron-side handshake signal SHALL be asserted per cycle.
REQ-022 start SHALL be ignored while busy=1; mode changes while busy SHALL NOT affect train.
REQ-023 Latency: a single-cycle sample-to-argument_valid path; each state transition takes effect on the clock edge of its handshake.
REQ-024 A valid input SHALL NOT be accepted in the same cycle as the state entry (a registered ready is allowed); handshakes SHALL be valid&ready only.

Reset
REQ-025 On reset=1 the block SHALL enter IDLE and set busy=0, done=0, all valid/ready outputs 0, train=0, counters and accumulator 0; data outputs SHALL be 0.
REQ-026 Reset asserted mid-run (any state) SHALL abort the run within one cycle, with no done pulse and no pending handshake completed.

Verification
REQ-027 Bench SHALL cover: SAMPLES=2, EPOCHS=1, mode=1, targets 100 and -50, neuron results 40 and 10 -> error_data 60 then -60, loss_data 120, done pulse, busy 0.
REQ-028 Bench SHALL cover: mode=0, SAMPLES=2, EPOCHS=1, target 0, result 16'h7FFF -> no error_valid or propagate_ready ever asserted, loss_data 65534.
REQ-029 Bench SHALL cover: target -32768, result 32767 -> error_data 16'h8000 (saturated), loss increment 32768.
REQ-030 Bench SHALL cover: argument_ready, error_ready, loss_ready held low 5 cycles each -> outputs stable and valids held, no sample lost.
REQ-031 Bench SHALL cover: reset asserted while in ERR -> next cycle error_valid=0, busy=0; a following start runs normally from sample 0.
REQ-032 Bench SHALL cover: start pulsed repeatedly during a run with EPOCHS=3 -> exactly 3 loss handshakes and one done pulse.
